// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types, constants and helpers for the two-road traffic light controller.
package traffic_light_ctrl_pkg;

    localparam int unsigned REM_W   = 7;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        ST_G1    = 3'd0,
        ST_Y1    = 3'd1,
        ST_AR1   = 3'd2,
        ST_G2    = 3'd3,
        ST_Y2    = 3'd4,
        ST_AR2   = 3'd5,
        ST_NIGHT = 3'd6
    } state_e;

    typedef struct packed {
        logic xanh;
        logic vang;
        logic red;
    } lamp_t;

    localparam lamp_t LAMP_OFF    = 3'b000;
    localparam lamp_t LAMP_GREEN  = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_RED    = 3'b001;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [SEG_W-1:0] digit_to_seg(input logic [DIGIT_W-1:0] digit);
        case (digit)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Nominal successor in the day cycle; NIGHT resumes through AR2.
    function automatic state_e cycle_succ(input state_e st);
        case (st)
            ST_G1:    return ST_Y1;
            ST_Y1:    return ST_AR1;
            ST_AR1:   return ST_G2;
            ST_G2:    return ST_Y2;
            ST_Y2:    return ST_AR2;
            ST_AR2:   return ST_G1;
            ST_NIGHT: return ST_AR2;
            default:  return ST_G1;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Night request in, lamps / countdown displays / second tick out.
interface traffic_light_ctrl_if;
    import traffic_light_ctrl_pkg::*;

    logic             night_mode;
    logic             xanh_1, vang_1, do_1;
    logic             xanh_2, vang_2, do_2;
    logic [SEG_W-1:0] seg1_hi, seg1_lo;
    logic [SEG_W-1:0] seg2_hi, seg2_lo;
    logic             sec_tick;

    modport master (
        output night_mode,
        input  xanh_1, vang_1, do_1, xanh_2, vang_2, do_2,
        input  seg1_hi, seg1_lo, seg2_hi, seg2_lo, sec_tick
    );

    modport slave (
        input  night_mode,
        output xanh_1, vang_1, do_1, xanh_2, vang_2, do_2,
        output seg1_hi, seg1_lo, seg2_hi, seg2_lo, sec_tick
    );
endinterface

// File: rtl/seven_segment_display.sv
// BCD digit to active-low seven-segment pattern with blanking.
module seven_segment_display
    import traffic_light_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_blank,
    output logic [SEG_W-1:0]   o_seg_c
);
    // Blank overrides the digit.
    always_comb begin
        o_seg_c = i_blank ? SEG_BLANK : digit_to_seg(i_digit);
    end
endmodule

// File: rtl/tick_gen.sv
// One-second enable: counts 0..CLK_HZ-1, flags the terminal count.
module tick_gen #(
    parameter int unsigned CLK_HZ = 125000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick_c
);
    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;

    // Free-running prescaler; clear restarts a full-length second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == CNT_MAX)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick_c = (r_cnt == CNT_MAX);
endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light with per-road countdown displays and night flashing mode.
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 125000000,
    parameter int unsigned GREEN_S  = 7,
    parameter int unsigned YELLOW_S = 3,
    parameter int unsigned ALLRED_S = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    traffic_light_ctrl_if.slave   bus
);
    localparam logic [REM_W-1:0] DUR_G   = REM_W'(GREEN_S);
    localparam logic [REM_W-1:0] DUR_Y   = REM_W'(YELLOW_S);
    localparam logic [REM_W-1:0] DUR_A   = REM_W'(ALLRED_S);
    localparam logic [REM_W-1:0] SUM_YA  = REM_W'(YELLOW_S + ALLRED_S);
    localparam logic [REM_W-1:0] SUM_GYA = REM_W'(GREEN_S + YELLOW_S + ALLRED_S);

    state_e             r_state, w_next_state, w_succ;
    logic [REM_W-1:0]   r_rem, w_next_rem;
    logic               r_flash, w_next_flash;
    logic               w_tick, w_clr;
    lamp_t              w_lamp1, w_lamp2;
    logic [REM_W-1:0]   w_disp1, w_disp2;
    logic               w_blank;
    logic [DIGIT_W-1:0] w_d1_hi, w_d1_lo, w_d2_hi, w_d2_lo;

    function automatic logic [REM_W-1:0] phase_dur(input state_e st);
        case (st)
            ST_G1, ST_G2:   return DUR_G;
            ST_Y1, ST_Y2:   return DUR_Y;
            ST_AR1, ST_AR2: return DUR_A;
            default:        return '0;
        endcase
    endfunction

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (w_clr),
        .o_tick_c (w_tick)
    );

    // State, remaining seconds and night flash bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_G1;
            r_rem   <= DUR_G;
            r_flash <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
            r_flash <= w_next_flash;
        end
    end

    // Next state: night request wins over everything, zero-length phases are skipped.
    always_comb begin
        w_next_state = r_state;
        w_next_rem   = r_rem;
        w_next_flash = r_flash;
        w_succ       = cycle_succ(r_state);
        if (phase_dur(w_succ) == '0) begin
            w_succ = cycle_succ(w_succ);
        end
        if (bus.night_mode) begin
            w_next_state = ST_NIGHT;
            w_next_flash = (r_state != ST_NIGHT) ? 1'b1 : (r_flash ^ w_tick);
        end else if (r_state == ST_NIGHT) begin
            w_next_state = w_succ;
            w_next_rem   = phase_dur(w_succ);
            w_next_flash = 1'b0;
        end else if (w_tick) begin
            if (r_rem <= REM_W'(1)) begin
                w_next_state = w_succ;
                w_next_rem   = phase_dur(w_succ);
            end else begin
                w_next_rem = r_rem - REM_W'(1);
            end
        end
    end

    // Lamps and countdown values; a red road adds the phases until its green.
    always_comb begin
        w_lamp1 = LAMP_OFF;
        w_lamp2 = LAMP_OFF;
        w_disp1 = '0;
        w_disp2 = '0;
        w_blank = 1'b0;
        w_clr   = 1'b0;
        case (r_state)
            ST_G1: begin
                w_lamp1 = LAMP_GREEN;  w_lamp2 = LAMP_RED;
                w_disp1 = r_rem;       w_disp2 = r_rem + SUM_YA;
            end
            ST_Y1: begin
                w_lamp1 = LAMP_YELLOW; w_lamp2 = LAMP_RED;
                w_disp1 = r_rem;       w_disp2 = r_rem + DUR_A;
            end
            ST_AR1: begin
                w_lamp1 = LAMP_RED;    w_lamp2 = LAMP_RED;
                w_disp1 = r_rem + SUM_GYA; w_disp2 = r_rem;
            end
            ST_G2: begin
                w_lamp1 = LAMP_RED;    w_lamp2 = LAMP_GREEN;
                w_disp1 = r_rem + SUM_YA;  w_disp2 = r_rem;
            end
            ST_Y2: begin
                w_lamp1 = LAMP_RED;    w_lamp2 = LAMP_YELLOW;
                w_disp1 = r_rem + DUR_A;   w_disp2 = r_rem;
            end
            ST_AR2: begin
                w_lamp1 = LAMP_RED;    w_lamp2 = LAMP_RED;
                w_disp1 = r_rem;       w_disp2 = r_rem + SUM_GYA;
            end
            ST_NIGHT: begin
                w_lamp1 = r_flash ? LAMP_YELLOW : LAMP_OFF;
                w_lamp2 = r_flash ? LAMP_YELLOW : LAMP_OFF;
                w_blank = 1'b1;
                w_clr   = !bus.night_mode;
            end
            default: begin
                w_blank = 1'b1;
            end
        endcase
    end

    assign w_d1_hi = DIGIT_W'(w_disp1 / REM_W'(10));
    assign w_d1_lo = DIGIT_W'(w_disp1 % REM_W'(10));
    assign w_d2_hi = DIGIT_W'(w_disp2 / REM_W'(10));
    assign w_d2_lo = DIGIT_W'(w_disp2 % REM_W'(10));

    seven_segment_display u_seg1_hi (
        .i_digit (w_d1_hi), .i_blank (w_blank || (w_d1_hi == '0)), .o_seg_c (bus.seg1_hi)
    );
    seven_segment_display u_seg1_lo (
        .i_digit (w_d1_lo), .i_blank (w_blank), .o_seg_c (bus.seg1_lo)
    );
    seven_segment_display u_seg2_hi (
        .i_digit (w_d2_hi), .i_blank (w_blank || (w_d2_hi == '0)), .o_seg_c (bus.seg2_hi)
    );
    seven_segment_display u_seg2_lo (
        .i_digit (w_d2_lo), .i_blank (w_blank), .o_seg_c (bus.seg2_lo)
    );

    assign bus.xanh_1   = w_lamp1.xanh;
    assign bus.vang_1   = w_lamp1.vang;
    assign bus.do_1     = w_lamp1.red;
    assign bus.xanh_2   = w_lamp2.xanh;
    assign bus.vang_2   = w_lamp2.vang;
    assign bus.do_2     = w_lamp2.red;
    assign bus.sec_tick = w_tick;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: default timing (A) and zero all-red build (B), CLK_HZ=10.
module tb_traffic_light_ctrl;
    localparam int HZ = 10;
    localparam int G  = 7;
    localparam int Y  = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    traffic_light_ctrl_if bus_a ();
    traffic_light_ctrl_if bus_b ();

    traffic_light_ctrl #(.CLK_HZ(HZ), .GREEN_S(G), .YELLOW_S(Y), .ALLRED_S(1)) dut_a (
        .clk (clk), .reset (rst), .bus (bus_a)
    );
    traffic_light_ctrl #(.CLK_HZ(HZ), .GREEN_S(G), .YELLOW_S(Y), .ALLRED_S(0)) dut_b (
        .clk (clk), .reset (rst), .bus (bus_b)
    );

    always #5 clk = ~clk;

    logic [34:0] obs_a, obs_b;
    assign obs_a = {bus_a.xanh_1, bus_a.vang_1, bus_a.do_1, bus_a.xanh_2, bus_a.vang_2, bus_a.do_2,
                    bus_a.seg1_hi, bus_a.seg1_lo, bus_a.seg2_hi, bus_a.seg2_lo, bus_a.sec_tick};
    assign obs_b = {bus_b.xanh_1, bus_b.vang_1, bus_b.do_1, bus_b.xanh_2, bus_b.vang_2, bus_b.do_2,
                    bus_b.seg1_hi, bus_b.seg1_lo, bus_b.seg2_hi, bus_b.seg2_lo, bus_b.sec_tick};

    // Reference: cycles since the last timing epoch (reset release or night exit),
    // the phase the epoch started in, and night flashing status.
    int m_k_a, m_p0_a, m_k_b;
    bit m_night_a, m_flash_a;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k_a <= 0; m_p0_a <= 0; m_night_a <= 1'b0; m_flash_a <= 1'b0; m_k_b <= 0;
        end else begin
            m_k_b <= m_k_b + 1;
            if (bus_a.night_mode) begin
                m_night_a <= 1'b1;
                m_flash_a <= !m_night_a ? 1'b1 : (m_flash_a ^ (m_k_a % HZ == HZ - 1));
                m_k_a     <= m_k_a + 1;
            end else if (m_night_a) begin
                m_night_a <= 1'b0; m_flash_a <= 1'b0; m_k_a <= 0; m_p0_a <= 5;
            end else begin
                m_k_a <= m_k_a + 1;
            end
        end
    end

    // Phase order G1,Y1,AR1,G2,Y2,AR2 = 0..5
    function automatic int dur(input int p, input int a);
        case (p % 3)
            0:       return G;
            1:       return Y;
            default: return a;
        endcase
    endfunction

    // Walk the schedule by elapsed whole seconds.
    function automatic void locate(input int k, input int p0, input int a, output int p, output int rem);
        int s, r;
        s = k / HZ;
        p = p0;
        r = dur(p, a);
        while (s >= r) begin
            s = s - r;
            p = (p + 1) % 6;
            r = dur(p, a);
        end
        rem = r - s;
    endfunction

    // 0 green, 1 yellow, 2 red
    function automatic int colour(input int road, input int p);
        if (road == 1) return (p == 0) ? 0 : (p == 1) ? 1 : 2;
        return (p == 3) ? 0 : (p == 4) ? 1 : 2;
    endfunction

    function automatic int until_change(input int road, input int p, input int rem, input int a);
        int t, q;
        t = rem;
        q = (p + 1) % 6;
        while (colour(road, q) == colour(road, p)) begin
            t = t + dur(q, a);
            q = (q + 1) % 6;
        end
        return t;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
            5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [13:0] disp_of(input int v);
        return {((v / 10) == 0) ? 7'h7F : seg_of(v / 10), seg_of(v % 10)};
    endfunction

    function automatic logic [34:0] exp_vec(input int k, input int p0, input int a, input bit night, input bit flash);
        int p, rem, c1, c2;
        logic [5:0]  l;
        logic [27:0] s;
        if (night) begin
            l = {1'b0, flash, 1'b0, 1'b0, flash, 1'b0};
            s = {4{7'h7F}};
        end else begin
            locate(k, p0, a, p, rem);
            c1 = colour(1, p);
            c2 = colour(2, p);
            l = {c1 == 0, c1 == 1, c1 == 2, c2 == 0, c2 == 1, c2 == 2};
            s = {disp_of(until_change(1, p, rem, a)), disp_of(until_change(2, p, rem, a))};
        end
        return {l, s, (k % HZ == HZ - 1)};
    endfunction

    task automatic test_reset();
        logic [34:0] e;
        rst = 1'b0;
        bus_a.night_mode = 1'b0;
        bus_b.night_mode = 1'b0;
        #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            e = exp_vec(m_k_a, m_p0_a, 1, m_night_a, m_flash_a);
            n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL reset_a t=%0t got=%h exp=%h", $time, obs_a, e); end
            e = exp_vec(m_k_b, 0, 0, 1'b0, 1'b0);
            n_checks++;
            if (obs_b !== e) begin n_fail++; $display("FAIL reset_b t=%0t got=%h exp=%h", $time, obs_b, e); end
        end
        n_checks++;
        if ({bus_a.seg1_hi, bus_a.seg1_lo, bus_a.seg2_hi, bus_a.seg2_lo} !== {7'h7F, 7'h78, 7'h79, 7'h79}) begin
            n_fail++;
            $display("FAIL reset_disp got=%h exp=%h", {bus_a.seg1_hi, bus_a.seg1_lo, bus_a.seg2_hi, bus_a.seg2_lo},
                     {7'h7F, 7'h78, 7'h79, 7'h79});
        end
    endtask

    task automatic test_cycle();
        logic [34:0] e;
        rst = 1'b0;
        repeat (240) begin
            @(negedge clk);
            e = exp_vec(m_k_a, m_p0_a, 1, m_night_a, m_flash_a);
            n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL cycle_a k=%0d got=%h exp=%h", m_k_a, obs_a, e); end
            e = exp_vec(m_k_b, 0, 0, 1'b0, 1'b0);
            n_checks++;
            if (obs_b !== e) begin n_fail++; $display("FAIL cycle_b k=%0d got=%h exp=%h", m_k_b, obs_b, e); end
            n_checks++;
            if ((bus_b.do_1 & bus_b.do_2) !== 1'b0) begin
                n_fail++; $display("FAIL both_red_b k=%0d got=1 exp=0", m_k_b);
            end
            if (m_k_a == 10) begin
                n_checks++;
                if ({bus_a.seg1_hi, bus_a.seg1_lo, bus_a.seg2_hi, bus_a.seg2_lo} !== {7'h7F, 7'h02, 7'h79, 7'h40}) begin
                    n_fail++; $display("FAIL disp_6_10 got=%h", {bus_a.seg1_hi, bus_a.seg1_lo, bus_a.seg2_hi, bus_a.seg2_lo});
                end
            end
            if (m_k_a == 70) begin
                n_checks++;
                if ({bus_a.vang_1, bus_a.seg1_hi, bus_a.seg1_lo, bus_a.seg2_hi, bus_a.seg2_lo} !==
                    {1'b1, 7'h7F, 7'h30, 7'h7F, 7'h19}) begin
                    n_fail++; $display("FAIL y1_entry got=%h", {bus_a.vang_1, bus_a.seg1_lo, bus_a.seg2_lo});
                end
            end
            if (m_k_a == 220) begin
                n_checks++;
                if ({bus_a.xanh_1, bus_a.seg1_lo} !== {1'b1, 7'h78}) begin
                    n_fail++; $display("FAIL cycle_22s got=%h exp=%h", {bus_a.xanh_1, bus_a.seg1_lo}, {1'b1, 7'h78});
                end
            end
            if (m_k_b == 100) begin
                n_checks++;
                if (bus_b.xanh_2 !== 1'b1) begin n_fail++; $display("FAIL b_y1_to_g2 got=%b exp=1", bus_b.xanh_2); end
            end
        end
    endtask

    task automatic test_night();
        logic [34:0] e;
        int p, rem, n;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            locate(m_k_a, m_p0_a, 1, p, rem);
            found = !m_night_a && (p == 3) && (rem == 4);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL night_wait_g2 got=timeout exp=G2"); end
        bus_a.night_mode = 1'b1;
        n = $urandom_range(30, 55);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_vec(m_k_a, m_p0_a, 1, m_night_a, m_flash_a);
            n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL night_a i=%0d got=%h exp=%h", i, obs_a, e); end
            if (i == 0) begin
                n_checks++;
                if ({bus_a.xanh_1, bus_a.vang_1, bus_a.do_1, bus_a.xanh_2, bus_a.vang_2, bus_a.do_2,
                     bus_a.seg1_lo, bus_a.seg2_hi} !== {6'b010010, 7'h7F, 7'h7F}) begin
                    n_fail++; $display("FAIL night_entry got=%b", {bus_a.xanh_1, bus_a.vang_1, bus_a.do_1,
                                                               bus_a.xanh_2, bus_a.vang_2, bus_a.do_2});
                end
            end
        end
        bus_a.night_mode = 1'b0;
        repeat (25) begin
            @(negedge clk);
            e = exp_vec(m_k_a, m_p0_a, 1, m_night_a, m_flash_a);
            n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL night_exit_a k=%0d got=%h exp=%h", m_k_a, obs_a, e); end
            if (m_k_a == 9) begin
                n_checks++;
                if ({bus_a.do_1, bus_a.do_2} !== 2'b11) begin
                    n_fail++; $display("FAIL ar2_len got=%b exp=11", {bus_a.do_1, bus_a.do_2});
                end
            end
            if (m_k_a == 10) begin
                n_checks++;
                if ({bus_a.xanh_1, bus_a.seg1_hi, bus_a.seg1_lo} !== {1'b1, 7'h7F, 7'h78}) begin
                    n_fail++; $display("FAIL g1_after_night got=%h", {bus_a.xanh_1, bus_a.seg1_hi, bus_a.seg1_lo});
                end
            end
        end
    endtask

    task automatic test_night_tick_collision();
        logic [34:0] e;
        int p, rem;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            locate(m_k_a, m_p0_a, 1, p, rem);
            found = !m_night_a && (p == 1) && (rem == 1) && (m_k_a % HZ == HZ - 1);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL collide_wait got=timeout exp=Y1_last_tick"); end
        bus_a.night_mode = 1'b1;
        @(negedge clk);
        e = exp_vec(m_k_a, m_p0_a, 1, m_night_a, m_flash_a);
        n_checks++;
        if (obs_a !== e) begin n_fail++; $display("FAIL collide_a got=%h exp=%h", obs_a, e); end
        n_checks++;
        if ({bus_a.vang_1, bus_a.do_1, bus_a.do_2} !== 3'b100) begin
            n_fail++; $display("FAIL collide_night got=%b exp=100", {bus_a.vang_1, bus_a.do_1, bus_a.do_2});
        end
        repeat (5) @(negedge clk);
        bus_a.night_mode = 1'b0;
        repeat (15) begin
            @(negedge clk);
            e = exp_vec(m_k_a, m_p0_a, 1, m_night_a, m_flash_a);
            n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL collide_exit_a got=%h exp=%h", obs_a, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [34:0] e;
        int p, rem;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            locate(m_k_a, m_p0_a, 1, p, rem);
            found = !m_night_a && (p == 4);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL areset_wait got=timeout exp=Y2"); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_a.xanh_1, bus_a.vang_1, bus_a.do_1, bus_a.xanh_2, bus_a.vang_2, bus_a.do_2} !== 6'b100001) begin
            n_fail++; $display("FAIL areset_lamps got=%b exp=100001", {bus_a.xanh_1, bus_a.vang_1, bus_a.do_1,
                                                                      bus_a.xanh_2, bus_a.vang_2, bus_a.do_2});
        end
        e = exp_vec(m_k_a, m_p0_a, 1, m_night_a, m_flash_a);
        n_checks++;
        if (obs_a !== e) begin n_fail++; $display("FAIL areset_a got=%h exp=%h", obs_a, e); end
        e = exp_vec(m_k_b, 0, 0, 1'b0, 1'b0);
        n_checks++;
        if (obs_b !== e) begin n_fail++; $display("FAIL areset_b got=%h exp=%h", obs_b, e); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            e = exp_vec(m_k_a, m_p0_a, 1, m_night_a, m_flash_a);
            n_checks++;
            if (obs_a !== e) begin n_fail++; $display("FAIL post_reset_a k=%0d got=%h exp=%h", m_k_a, obs_a, e); end
            e = exp_vec(m_k_b, 0, 0, 1'b0, 1'b0);
            n_checks++;
            if (obs_b !== e) begin n_fail++; $display("FAIL post_reset_b k=%0d got=%h exp=%h", m_k_b, obs_b, e); end
        end
    endtask

    task automatic test_random_night();
        logic [34:0] e;
        int n;
        repeat (10) begin
            bus_a.night_mode = 1'($urandom_range(0, 1));
            n = $urandom_range(3, 45);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                e = exp_vec(m_k_a, m_p0_a, 1, m_night_a, m_flash_a);
                n_checks++;
                if (obs_a !== e) begin n_fail++; $display("FAIL random_a k=%0d got=%h exp=%h", m_k_a, obs_a, e); end
                e = exp_vec(m_k_b, 0, 0, 1'b0, 1'b0);
                n_checks++;
                if (obs_b !== e) begin n_fail++; $display("FAIL random_b k=%0d got=%h exp=%h", m_k_b, obs_b, e); end
            end
        end
        bus_a.night_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_night();
        test_night_tick_collision();
        test_async_reset();
        test_random_night();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 125000000: input clock frequency; the 1 s tick period in cycles.
REQ-002 Parameter GREEN_S, default 7: green duration per road in seconds, legal range 1..90.
REQ-003 Parameter YELLOW_S, default 3: yellow duration per road in seconds, legal range 1..9.
REQ-004 Parameter ALLRED_S, default 1: all-red clearance between roads in seconds, legal range 0..9; GREEN_S+YELLOW_S+2*ALLRED_S SHALL be at most 99.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 night_mode  in  1  level request for flashing-yellow operation, synchronous to clk.
REQ-008 xanh_1, vang_1, do_1  out  1 each  road 1 green/yellow/red lamps, active high.
REQ-009 xanh_2, vang_2, do_2  out  1 each  road 2 green/yellow/red lamps, active high.
REQ-010 seg1_hi, seg1_lo  out  7 each  road 1 countdown tens/ones digits, active-low segments.
REQ-011 seg2_hi, seg2_lo  out  7 each  road 2 countdown tens/ones digits, active-low segments.
REQ-012 sec_tick  out  1  one-cycle pulse each elapsed second, for observation.

Function
REQ-013 A prescaler SHALL count 0..CLK_HZ-1 and assert sec_tick for one cycle when it reaches CLK_HZ-1; all timing SHALL use this enable, and no derived clock is permitted.
REQ-014 States SHALL be G1, Y1, AR1, G2, Y2, AR2, NIGHT, with durations GREEN_S, YELLOW_S, ALLRED_S, GREEN_S, YELLOW_S, ALLRED_S; the cycle order is G1->Y1->AR1->G2->Y2->AR2->G1.
REQ-015 A state with zero duration (AR1/AR2 when ALLRED_S=0) SHALL be skipped: its successor is entered directly.
REQ-016 On state entry, a remaining-seconds counter SHALL load the state duration; it decrements on sec_tick; a sec_tick while it equals 1 advances the state.
REQ-017 Lamps SHALL be exactly one-hot per road: in G1 xanh_1 and do_2; in Y1 vang_1 and do_2; in AR1/AR2 do_1 and do_2; in G2 do_1 and xanh_2; in Y2 do_1 and vang_2.
REQ-018 Each road display SHALL show the seconds until that road's lamp next changes colour.
REQ-019 For a road in green or yellow, the display value is the remaining count.
REQ-020 For a road in red, the display value is the remaining count plus the durations of all following states until that road turns green.
REQ-021 Display values (at most 99) SHALL be split into tens and ones, with the tens digit blanked (7'h7F) when zero.
REQ-022 Displays SHALL be combinational from registered state, with no added latency.
REQ-023 night_mode=1 sampled at any clock edge SHALL move the block to NIGHT on that edge from any state.
REQ-024 In NIGHT, all xanh and do lamps are 0, vang_1=vang_2 toggles on every sec_tick starting from 1, and all four displays show 7'h7F.
REQ-025 night_mode=0 in NIGHT SHALL enter AR2 (or G1 if ALLRED_S=0) and clear the prescaler, so the first second is full-length.
REQ-026 night_mode has priority over a simultaneous state-advance tick.

Reset
REQ-027 While reset=1, the block SHALL be in state G1 with remaining count GREEN_S, prescaler 0, sec_tick 0, and the NIGHT flash bit 0.
REQ-028 Outputs during reset SHALL be xanh_1=1, do_2=1, and all other lamps 0.
REQ-029 Displays during reset SHALL show road 1 at GREEN_S and road 2 at GREEN_S+YELLOW_S+ALLRED_S.
REQ-030 Reset asserted mid-phase or in NIGHT SHALL override everything asynchronously; release resumes from G1.

Structure
REQ-031 A shared package SHALL hold the state enumeration (3 bits), the blank-segment constant 7'h7F, and the digit-to-segment table.
REQ-032 The prescaler width SHALL be $clog2(CLK_HZ) and the remaining counter 7 bits.
REQ-033 The existing seven_segment_display decoder SHALL be instantiated four times; the prescaler SHALL be a sub-module named tick_gen.

Verification (CLK_HZ=10 for all scenarios)
REQ-034 Release reset and run: sec_tick every 10 cycles; G1 for 7 s, Y1 3 s, AR1 1 s, G2 7 s, Y2 3 s, AR2 1 s; the full cycle takes 22 s.
REQ-035 Displays after reset: road1 "7", road2 "11"; one tick later "6"/"10" with the tens digit shown as "1"; at G1->Y1 road1 shows "3" and road2 shows "4".
REQ-036 Build with ALLRED_S=0: Y1->G2 occurs directly, and lamps are never both red.
REQ-037 Assert night_mode in the middle of G2: next edge gives lamps 0 except vang_1=vang_2 toggling every 10 cycles, and all displays are 7'h7F; deassert: AR2 for a full 10 cycles, then G1 with display "7".
REQ-038 Assert reset asynchronously between clock edges during Y2: outputs immediately show xanh_1=1 and do_2=1; night_mode coinciding with the last tick of Y1 results in NIGHT, not AR1.
